// File: rtl/microtile_switch_ctrl.sv
// Switch-over sequencer for micro-tiles sharing one I/O container: quiesces the
// outgoing tile, moves the output mux, then holds the incoming tile in reset before release.
module microtile_switch_ctrl #(
    parameter int N_TILES   = 4,
    parameter int SEL_W     = 2,
    parameter int GUARD_CYC = 2,
    parameter int RST_CYC   = 4,
    parameter int DWELL_CYC = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   req_sel,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               auto_en,
    output logic [SEL_W-1:0]   sel,
    output logic [N_TILES-1:0] tile_clk_en,
    output logic [N_TILES-1:0] tile_rst_n,
    output logic               busy,
    output logic               switch_done
);

    typedef enum logic [1:0] {
        RUN,
        QUIESCE,
        SWITCH,
        HOLD_RST
    } state_t;

    localparam int CNT_MAX = (GUARD_CYC > RST_CYC) ? GUARD_CYC : RST_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DWELL_W = $clog2(DWELL_CYC);

    localparam logic [CNT_W-1:0]   GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0]   RST_LAST   = CNT_W'(RST_CYC - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYC - 1);
    localparam logic [SEL_W-1:0]   LAST_TILE  = SEL_W'(N_TILES - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DWELL_W-1:0] dwell;
    logic [SEL_W-1:0]   target;

    logic               accept;
    logic               req_in_range;
    logic               expire;
    logic [SEL_W-1:0]   next_tile;

    function automatic logic [N_TILES-1:0] one_hot(input logic [SEL_W-1:0] idx);
        one_hot = {{(N_TILES-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign accept       = req_valid && req_ready;
    assign req_in_range = ({1'b0, req_sel} < (SEL_W+1)'(N_TILES));
    assign expire       = auto_en && (dwell == DWELL_LAST);
    assign next_tile    = (sel == LAST_TILE) ? '0 : sel + SEL_W'(1);

    // Outputs are registered alongside the state so they always show the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HOLD_RST;
            cnt         <= '0;
            dwell       <= '0;
            target      <= '0;
            sel         <= '0;
            tile_clk_en <= one_hot('0);
            tile_rst_n  <= '0;
            busy        <= 1'b1;
            req_ready   <= 1'b0;
            switch_done <= 1'b0;
        end else begin
            switch_done <= 1'b0;
            case (state)
                RUN: begin
                    // An out-of-range request is consumed but ignored, so auto-scan carries on.
                    if ((accept && req_in_range) || expire) begin
                        state       <= QUIESCE;
                        target      <= (accept && req_in_range) ? req_sel : next_tile;
                        cnt         <= '0;
                        dwell       <= '0;
                        tile_clk_en <= '0;
                        tile_rst_n  <= '0;
                        busy        <= 1'b1;
                        req_ready   <= 1'b0;
                    end else begin
                        dwell <= auto_en ? dwell + DWELL_W'(1) : '0;
                    end
                end
                QUIESCE: begin
                    if (cnt == GUARD_LAST) begin
                        state <= SWITCH;
                        sel   <= target;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SWITCH: begin
                    state       <= HOLD_RST;
                    cnt         <= '0;
                    tile_clk_en <= one_hot(sel);
                end
                HOLD_RST: begin
                    if (cnt == RST_LAST) begin
                        state       <= RUN;
                        cnt         <= '0;
                        dwell       <= '0;
                        tile_rst_n  <= one_hot(sel);
                        busy        <= 1'b0;
                        req_ready   <= 1'b1;
                        switch_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state       <= HOLD_RST;
                    cnt         <= '0;
                    tile_clk_en <= one_hot(sel);
                    tile_rst_n  <= '0;
                    busy        <= 1'b1;
                    req_ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microtile_switch_ctrl.sv
// Bench for microtile_switch_ctrl: directed switch sequences with cycle-exact checks,
// a scoreboard matched against every switch_done pulse, and per-cycle one-hot invariants.
module tb_microtile_switch_ctrl;

    localparam int N_TILES = 4;
    localparam int SEL_W   = 2;

    typedef struct packed {
        logic [SEL_W-1:0]   sel;
        logic [N_TILES-1:0] clk_en;
        logic [N_TILES-1:0] rst_n;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [SEL_W-1:0]   req_sel;
    logic               req_valid;
    logic               req_ready;
    logic               auto_en;
    logic [SEL_W-1:0]   sel;
    logic [N_TILES-1:0] tile_clk_en;
    logic [N_TILES-1:0] tile_rst_n;
    logic               busy;
    logic               switch_done;

    exp_t exp_q[$];
    exp_t mon_exp;
    int   errors = 0;
    int   checks = 0;

    microtile_switch_ctrl #(
        .N_TILES(N_TILES),
        .SEL_W(SEL_W),
        .GUARD_CYC(2),
        .RST_CYC(4),
        .DWELL_CYC(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_sel(req_sel),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .auto_en(auto_en),
        .sel(sel),
        .tile_clk_en(tile_clk_en),
        .tile_rst_n(tile_rst_n),
        .busy(busy),
        .switch_done(switch_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic valid, input logic [SEL_W-1:0] s, input logic a);
        req_valid = valid;
        req_sel   = s;
        auto_en   = a;
    endtask

    task automatic expect_switch(input logic [SEL_W-1:0] tile);
        exp_t e;
        e.sel    = tile;
        e.clk_en = 4'b0001 << tile;
        e.rst_n  = 4'b0001 << tile;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input string name, input logic [SEL_W-1:0] e_sel,
                                input logic [N_TILES-1:0] e_clk, input logic [N_TILES-1:0] e_rst,
                                input logic e_busy, input logic e_ready, input logic e_done);
        checks++;
        if (sel !== e_sel || tile_clk_en !== e_clk || tile_rst_n !== e_rst ||
            busy !== e_busy || req_ready !== e_ready || switch_done !== e_done) begin
            errors++;
            $display("[TB] FAIL %s: got sel=%0d clk_en=%b rst_n=%b busy=%b ready=%b done=%b, expected sel=%0d clk_en=%b rst_n=%b busy=%b ready=%b done=%b",
                     name, sel, tile_clk_en, tile_rst_n, busy, req_ready, switch_done,
                     e_sel, e_clk, e_rst, e_busy, e_ready, e_done);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (switch_done !== 1'b1 && n < budget);
        checks++;
        if (switch_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: switch_done not seen within %0d cycles", name, budget);
        end
    endtask

    // Monitor: one-hot/busy invariants every cycle, scoreboard pop on every completed switch.
    always @(negedge clk) begin
        checks++;
        if ($countones(tile_clk_en) > 1 || $countones(tile_rst_n) > 1 ||
            busy !== (tile_rst_n == '0) || busy === req_ready) begin
            errors++;
            $display("[TB] FAIL invariant: clk_en=%b rst_n=%b busy=%b ready=%b",
                     tile_clk_en, tile_rst_n, busy, req_ready);
        end
        if (switch_done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL scoreboard: unexpected switch_done with sel=%0d, expected none", sel);
            end else begin
                mon_exp = exp_q.pop_front();
                if (sel !== mon_exp.sel || tile_clk_en !== mon_exp.clk_en || tile_rst_n !== mon_exp.rst_n) begin
                    errors++;
                    $display("[TB] FAIL scoreboard: got sel=%0d clk_en=%b rst_n=%b, expected sel=%0d clk_en=%b rst_n=%b",
                             sel, tile_clk_en, tile_rst_n, mon_exp.sel, mon_exp.clk_en, mon_exp.rst_n);
                end
            end
        end
    end

    initial begin
        apply_stimulus(1'b0, 2'd0, 1'b0);
        rst = 1'b1;
        repeat (2) tick();
        check_output("reset", 2'd0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Reset release: four HOLD_RST cycles on tile 0, then RUN.
        expect_switch(2'd0);
        rst = 1'b0;
        check_output("rst_hold", 2'd0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check_output("rst_hold", 2'd0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
        end
        tick();
        check_output("rst_run", 2'd0, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1);
        tick();
        check_output("run_idle", 2'd0, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0);

        // Switch to tile 2 with cycle-exact sequence.
        expect_switch(2'd2);
        apply_stimulus(1'b1, 2'd2, 1'b0);
        tick();
        apply_stimulus(1'b0, 2'd0, 1'b0);
        check_output("quiesce_a", 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        tick();
        check_output("quiesce_b", 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        tick();
        check_output("switch_t2", 2'd2, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("hold_t2", 2'd2, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0);
        end
        tick();
        check_output("run_t2", 2'd2, 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1);

        // Request held through a busy sequence is taken on the first RUN cycle.
        expect_switch(2'd1);
        apply_stimulus(1'b1, 2'd1, 1'b0);
        tick();
        expect_switch(2'd3);
        apply_stimulus(1'b1, 2'd3, 1'b0);
        for (int i = 0; i < 7; i++) begin
            check_bit("ready_while_busy", req_ready, 1'b0);
            tick();
        end
        check_output("run_t1", 2'd1, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1);
        tick();
        apply_stimulus(1'b0, 2'd0, 1'b0);
        check_output("held_accept", 2'd1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        wait_done("held_t3", 12);
        check_output("run_t3", 2'd3, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b1);

        // Same-tile request re-resets tile 3 without moving sel.
        expect_switch(2'd3);
        apply_stimulus(1'b1, 2'd3, 1'b0);
        tick();
        apply_stimulus(1'b0, 2'd0, 1'b0);
        check_output("rereset_quiesce", 2'd3, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        wait_done("rereset", 12);
        check_output("rereset_run", 2'd3, 4'b1000, 4'b1000, 0, 1'b1, 1'b1);

        // Auto-scan with 8-cycle dwell: 3 -> 0 -> 1 -> 2 -> 3 -> 0 -> 1.
        apply_stimulus(1'b0, 2'd0, 1'b1);
        expect_switch(2'd0);
        wait_done("auto_0", 20);
        check_output("auto_run_0", 2'd0, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check_bit("dwell_run", busy, 1'b0);
        end
        tick();
        check_bit("dwell_expire", busy, 1'b1);
        expect_switch(2'd1);
        wait_done("auto_1", 20);
        check_output("auto_run_1", 2'd1, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1);
        expect_switch(2'd2);
        wait_done("auto_2", 20);
        check_output("auto_run_2", 2'd2, 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1);
        expect_switch(2'd3);
        wait_done("auto_3", 20);
        check_output("auto_run_3", 2'd3, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b1);
        expect_switch(2'd0);
        wait_done("auto_wrap", 20);
        check_output("auto_run_wrap", 2'd0, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1);
        expect_switch(2'd1);
        wait_done("auto_1b", 20);
        check_output("auto_run_1b", 2'd1, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1);

        // Explicit request on the expiry cycle beats the auto target (2).
        repeat (7) tick();
        expect_switch(2'd1);
        apply_stimulus(1'b1, 2'd1, 1'b1);
        tick();
        apply_stimulus(1'b0, 2'd0, 1'b0);
        check_output("expiry_accept", 2'd1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        wait_done("expiry_req", 12);
        check_output("expiry_run", 2'd1, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of HOLD_RST toward tile 2.
        expect_switch(2'd0);
        apply_stimulus(1'b1, 2'd2, 1'b0);
        tick();
        apply_stimulus(1'b0, 2'd0, 1'b0);
        repeat (4) tick();
        check_output("hold_before_rst", 2'd2, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_output("async_rst", 2'd0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("replay_hold", 2'd0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
        end
        tick();
        check_output("replay_run", 2'd0, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1);

        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d pending switches, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
